// File: rtl/serial_adder_ctrl_pkg.sv
// Shared types and helpers for the bit-serial adder sequencer.
package serial_adder_ctrl_pkg;

    // Controller states; code 2'd3 is unused and decodes back to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Bit-counter width: ceil(log2(width)), never less than one bit.
    function automatic int cnt_w(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Operand/result valid-ready bundle between a source, the serial adder and a sink.
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;

    // Source/sink side: drives operands and result acceptance.
    modport master (
        output in_valid, in_a, in_b, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf
    );

    // Adder side: accepts operands and presents the result.
    modport slave (
        input  in_valid, in_a, in_b, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf
    );
endinterface

// File: rtl/full_adder.sv
// Single-bit full adder cell: {co, s} = a + b + ci.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: one full_adder cell adds two WIDTH-bit operands
// LSB first, one bit per clock, with carry held in a flop between slices.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    serial_adder_ctrl_if.slave bus,
    output logic               busy
);

    localparam int               CNT_W    = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
    logic [WIDTH-1:0] sum_shifted;
    logic             carry_q, carry_d;
    logic             cin_msb_q, cin_msb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fa_s, fa_co;

    // The only arithmetic in the datapath: the shared bit-slice adder.
    full_adder u_fa (
        .a  (a_sh_q[0]),
        .b  (b_sh_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    // New sum bit enters at the MSB; a 1-bit build has nothing to shift down.
    generate
        if (WIDTH == 1) begin : g_sum_w1
            assign sum_shifted = fa_s;
        end else begin : g_sum_wn
            assign sum_shifted = {fa_s, sum_sh_q[WIDTH-1:1]};
        end
    endgenerate

    // Next-state and datapath update for each state.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d   = state_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        sum_sh_d  = sum_sh_q;
        carry_d   = carry_q;
        cin_msb_d = cin_msb_q;
        cnt_d     = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    a_sh_d  = bus.in_a;
                    b_sh_d  = bus.in_b;
                    carry_d = bus.in_cin;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                sum_sh_d = sum_shifted;
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                carry_d  = fa_co;
                if (cnt_q == CNT_LAST) begin
                    // Carry going into the MSB slice, needed for signed overflow.
                    cin_msb_d = carry_q;
                    state_d   = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; synchronous reset wins over any handshake.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            state_q   <= ST_IDLE;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            sum_sh_q  <= '0;
            carry_q   <= 1'b0;
            cin_msb_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            a_sh_q    <= a_sh_d;
            b_sh_q    <= b_sh_d;
            sum_sh_q  <= sum_sh_d;
            carry_q   <= carry_d;
            cin_msb_q <= cin_msb_d;
            cnt_q     <= cnt_d;
        end
    end

    // Handshake flags decode straight from state; result fields come from the
    // registers, so they hold the last result while out_valid qualifies them.
    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign busy          = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign bus.out_sum   = sum_sh_q;
    assign bus.out_cout  = carry_q;
    assign bus.out_ovf   = cin_msb_q ^ carry_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed cases on WIDTH=8 and
// WIDTH=1 builds, then a randomized handshake regression against an
// arithmetic reference model.
module tb_serial_adder_ctrl;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic busy8;
    logic busy1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl_if #(.WIDTH(8)) bus8 ();
    serial_adder_ctrl_if #(.WIDTH(1)) bus1 ();

    serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus8),
        .busy (busy8)
    );

    serial_adder_ctrl #(.WIDTH(1)) u_dut1 (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus1),
        .busy (busy1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer addition; overflow from the signed interpretation.
    task automatic model(input int w, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, output exp_t e);
        longint full, span, sa, sb, ss;
        span   = longint'(1) << w;
        full   = longint'(a) + longint'(b) + longint'(cin);
        e.sum  = 32'(full % span);
        e.cout = (full >= span);
        sa     = (longint'(a) >= span / 2) ? longint'(a) - span : longint'(a);
        sb     = (longint'(b) >= span / 2) ? longint'(b) - span : longint'(b);
        ss     = sa + sb + longint'(cin);
        e.ovf  = (ss > span / 2 - 1) || (ss < -(span / 2));
    endtask

    // One WIDTH=8 operation with latency check and optional result backpressure.
    task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic cin, input int hold);
        exp_t e;
        int   lat;
        model(8, {24'd0, a}, {24'd0, b}, cin, e);
        check({tag, "/in_ready"}, bus8.in_ready, 1);
        bus8.in_valid = 1'b1;
        bus8.in_a     = a;
        bus8.in_b     = b;
        bus8.in_cin   = cin;
        tick();
        bus8.in_valid = 1'b0;
        lat = 0;
        while (!bus8.out_valid && lat < 40) begin
            tick();
            lat++;
        end
        check({tag, "/latency"}, lat, 8);
        check({tag, "/sum"}, bus8.out_sum, e.sum);
        check({tag, "/cout"}, bus8.out_cout, e.cout);
        check({tag, "/ovf"}, bus8.out_ovf, e.ovf);
        for (int i = 0; i < hold; i++) begin
            bus8.in_valid = 1'b1;
            bus8.in_a     = 8'h11;
            bus8.in_b     = 8'($urandom);
            tick();
            check({tag, "/hold_sum"}, bus8.out_sum, e.sum);
            check({tag, "/hold_cout"}, bus8.out_cout, e.cout);
            check({tag, "/hold_ovf"}, bus8.out_ovf, e.ovf);
            check({tag, "/hold_valid"}, bus8.out_valid, 1);
            check({tag, "/hold_in_ready"}, bus8.in_ready, 0);
        end
        bus8.in_valid  = 1'b0;
        bus8.out_ready = 1'b1;
        tick();
        bus8.out_ready = 1'b0;
        check({tag, "/post_in_ready"}, bus8.in_ready, 1);
        check({tag, "/post_valid"}, bus8.out_valid, 0);
    endtask

    // One WIDTH=1 operation: a single RUN cycle.
    task automatic op1(input logic a, input logic b, input logic cin);
        exp_t  e;
        int    lat;
        string tag;
        tag = $sformatf("w1_%0d%0d%0d", a, b, cin);
        model(1, {31'd0, a}, {31'd0, b}, cin, e);
        bus1.in_valid = 1'b1;
        bus1.in_a     = a;
        bus1.in_b     = b;
        bus1.in_cin   = cin;
        tick();
        bus1.in_valid = 1'b0;
        lat = 0;
        while (!bus1.out_valid && lat < 10) begin
            tick();
            lat++;
        end
        check({tag, "/latency"}, lat, 1);
        check({tag, "/sum"}, bus1.out_sum, e.sum);
        check({tag, "/cout"}, bus1.out_cout, e.cout);
        check({tag, "/ovf"}, bus1.out_ovf, e.ovf);
        bus1.out_ready = 1'b1;
        tick();
        bus1.out_ready = 1'b0;
    endtask

    initial begin
        exp_t e;
        exp_t q[$];
        int   acc, got, cyc;

        rst            = 1'b1;
        bus8.in_valid  = 1'b0;
        bus8.in_a      = '0;
        bus8.in_b      = '0;
        bus8.in_cin    = 1'b0;
        bus8.out_ready = 1'b0;
        bus1.in_valid  = 1'b0;
        bus1.in_a      = '0;
        bus1.in_b      = '0;
        bus1.in_cin    = 1'b0;
        bus1.out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst/in_ready", bus8.in_ready, 1);
        check("rst/out_valid", bus8.out_valid, 0);
        check("rst/busy", busy8, 0);
        check("rst/sum", bus8.out_sum, 0);
        check("rst/cout", bus8.out_cout, 0);
        check("rst/ovf", bus8.out_ovf, 0);

        // Directed WIDTH=8 cases
        op8("d5a3c", 8'h5A, 8'h3C, 1'b0, 0);
        op8("dff01", 8'hFF, 8'h01, 1'b0, 0);
        op8("dff00c", 8'hFF, 8'h00, 1'b1, 0);
        op8("d8080", 8'h80, 8'h80, 1'b0, 0);

        // Backpressure: result held for 5 cycles while a new operand is offered
        op8("bp", 8'h7F, 8'h01, 1'b1, 5);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp/no_queue_valid", bus8.out_valid, 0);
            check("bp/no_queue_busy", busy8, 0);
        end

        // Reset in the middle of RUN discards the operation
        bus8.in_valid = 1'b1;
        bus8.in_a     = 8'hC3;
        bus8.in_b     = 8'h5D;
        bus8.in_cin   = 1'b1;
        tick();
        bus8.in_valid = 1'b0;
        tick();
        tick();
        check("mid/busy_before", busy8, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid/in_ready", bus8.in_ready, 1);
        check("mid/out_valid", bus8.out_valid, 0);
        check("mid/sum", bus8.out_sum, 0);
        check("mid/busy", busy8, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("mid/never_valid", bus8.out_valid, 0);
        end
        op8("mid_next", 8'h01, 8'h02, 1'b0, 0);

        // WIDTH=1 build: every operand combination
        for (int k = 0; k < 8; k++) begin
            op1(k[2], k[1], k[0]);
        end

        // Randomized regression with random in_valid / out_ready gaps
        acc = 0;
        got = 0;
        cyc = 0;
        while ((acc < 1000 || q.size() > 0) && cyc < 60000) begin
            bus8.in_valid  = (acc < 1000) && ($urandom_range(0, 1) == 1);
            bus8.in_a      = 8'($urandom);
            bus8.in_b      = 8'($urandom);
            bus8.in_cin    = 1'($urandom);
            bus8.out_ready = ($urandom_range(0, 4) != 0);
            if (bus8.in_valid && bus8.in_ready) begin
                model(8, {24'd0, bus8.in_a}, {24'd0, bus8.in_b}, bus8.in_cin, e);
                q.push_back(e);
                acc++;
            end
            if (bus8.out_valid && bus8.out_ready) begin
                got++;
                if (q.size() == 0) begin
                    check("rnd/spurious_result", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("rnd/sum", bus8.out_sum, e.sum);
                    check("rnd/cout", bus8.out_cout, e.cout);
                    check("rnd/ovf", bus8.out_ovf, e.ovf);
                end
            end
            tick();
            cyc++;
        end
        bus8.in_valid  = 1'b0;
        bus8.out_ready = 1'b0;
        check("rnd/accepted", acc, 1000);
        check("rnd/results", got, acc);
        check("rnd/drained", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial adder sequencer that time-multiplexes one full_adder cell (1-bit A+B+CI → S,CO) to add two WIDTH-bit operands, LSB first, one bit per clock.
- Sits between a valid/ready operand source and a valid/ready result sink; used in ap3 area-constrained test designs where one adder cell replaces a WIDTH-bit carry chain.
- Holds the carry in a flop between bit slices and reports sum, carry-out and signed overflow.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 1..32.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand set valid.
- in_ready  output  1  controller can accept operands.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_cin  input  1  initial carry-in.
- out_valid  output  1  result valid.
- out_ready  input  1  sink accepts result.
- out_sum  output  WIDTH  A+B+cin modulo 2^WIDTH.
- out_cout  output  1  unsigned carry-out.
- out_ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset: state IDLE; in_ready=1; out_valid=0, busy=0; out_sum=0, out_cout=0, out_ovf=0; shift registers, carry flop and bit counter cleared.
- States: IDLE, RUN, DONE. Encoding is binary; illegal codes go to IDLE.
- IDLE: in_ready=1. On in_valid&&in_ready: load a_sh←in_a, b_sh←in_b, carry←in_cin, cnt←0, go to RUN. Inputs are sampled only at this edge.
- RUN: in_ready=0. The full_adder inputs are a_sh[0], b_sh[0], carry. Each edge:
  - sum_sh ← {S, sum_sh[WIDTH-1:1]}
  - a_sh and b_sh shift right by 1
  - carry ← CO; cin_msb ← carry when cnt==WIDTH-1
  - cnt ← cnt+1
  - When cnt==WIDTH-1, go to DONE.
- DONE: out_valid=1. out_sum=sum_sh, out_cout=carry, out_ovf=cin_msb^carry. All three are held stable while out_valid && !out_ready. On out_ready, go to IDLE.
- Latency: out_valid rises exactly WIDTH cycles after the accept edge. Minimum initiation interval is WIDTH+2 cycles: accept, WIDTH RUN edges, result handshake edge.
- in_ready is low in RUN and DONE. Operands presented then are ignored and not queued.
- out_ready while not in DONE has no effect.
- Outputs in IDLE retain the last result, but out_valid=0 qualifies them.
- WIDTH=1: exactly one RUN cycle; ovf = in_cin ^ cout.
- Counter width: $clog2(WIDTH), minimum 1 bit. It never wraps, because the state leaves RUN at WIDTH-1.
- rst asserted in any state, including mid-RUN: next edge is reset state. The in-flight operation is discarded and no partial result is ever flagged valid.
- rst has priority over any simultaneous handshake.

Decomposition:
- serial_adder_pkg (Verilog include): state localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2; CNT_W function (clog2 with min 1).
- Sub-module: one instance of the existing full_adder cell as the bit-slice datapath, connected A/B/CI/S/CO directly. The controller contains no other arithmetic except the counter increment.

Test Plan:
- WIDTH=8, accept a=0x5A b=0x3C cin=0 → out_valid exactly 8 cycles after accept; sum=0x96, cout=0, ovf=1.
- WIDTH=8, a=0xFF b=0x01 cin=0 → sum=0x00, cout=1, ovf=0. Then a=0xFF b=0x00 cin=1 → sum=0x00, cout=1, ovf=0. Then a=0x80 b=0x80 cin=0 → sum=0x00, cout=1, ovf=1.
- Backpressure: out_ready=0 for 5 cycles after out_valid → sum, cout and ovf stable; in_ready=0; new in_valid with a=0x11 ignored. Raising out_ready gives in_ready=1 on the next cycle.
- Reset mid-operation: rst pulsed on the 3rd RUN cycle → next cycle IDLE, in_ready=1, out_valid=0, out_sum=0, busy=0. The following op a=0x01 b=0x02 → sum=0x03.
- WIDTH=1 build: a=1 b=1 cin=1 → out_valid 1 cycle after accept; sum=1, cout=1, ovf=0.
- Random regression: 1000 ops with random in_valid/out_ready gaps, compared against a {cout,sum}=a+b+cin model; ovf compared to the signed-overflow model; no result lost or duplicated.
